// File: rtl/imm_ext_pipe.sv
// Registered immediate extender (sign/zero/upper/branch) behind a 2-entry skid buffer.
// Optional output-handshake counter on xfer_cnt, enabled by defining IMM_EXT_STATS_EN.
module imm_ext_pipe #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [15:0]      xfer_cnt
);

    localparam int unsigned ExtW = OUT_W - IN_W;

    if (IN_W < 2 || OUT_W < IN_W + 2) begin : g_param_check
        $error("imm_ext_pipe: need IN_W >= 2 and OUT_W >= IN_W + 2");
    end

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [OUT_W-1:0] r_head;
    logic [OUT_W-1:0] r_tail;
    logic [OUT_W-1:0] w_sign;
    logic [OUT_W-1:0] w_ext;
    logic             w_acc;
    logic             w_del;

    assign w_sign = {{ExtW{in_imm[IN_W-1]}}, in_imm};

    always_comb begin
        w_ext = w_sign;
        unique case (in_mode)
            2'b00: w_ext = w_sign;
            2'b01: w_ext = {{ExtW{1'b0}}, in_imm};
            2'b10: w_ext = {in_imm, {ExtW{1'b0}}};
            2'b11: w_ext = {w_sign[OUT_W-3:0], 2'b00};
            default: w_ext = w_sign;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StEmpty: if (w_acc) w_state_nxt = StOne;
            StOne: begin
                if (w_acc && !w_del) begin
                    w_state_nxt = StFull;
                end else if (w_del && !w_acc) begin
                    w_state_nxt = StEmpty;
                end
            end
            StFull:  if (w_del) w_state_nxt = StOne;
            default: w_state_nxt = StEmpty;
        endcase
    end

    // Outputs depend on registered state only, so out_ready never reaches in_ready
    always_comb begin
        in_ready  = (r_state != StFull);
        out_valid = (r_state != StEmpty);
        out_data  = r_head;
    end

    assign w_acc = in_valid && in_ready;
    assign w_del = out_valid && out_ready;

    // r_head is always the oldest entry; r_tail only holds the second one when full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            unique case (r_state)
                StEmpty: if (w_acc) r_head <= w_ext;
                StOne: begin
                    if (w_acc && w_del) begin
                        r_head <= w_ext;
                    end else if (w_acc) begin
                        r_tail <= w_ext;
                    end
                end
                StFull:  if (w_del) r_head <= r_tail;
                default: ;
            endcase
        end
    end

`ifdef IMM_EXT_STATS_EN
    logic [15:0] r_xfer_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= 16'h0000;
        end else if (w_del && (r_xfer_cnt != 16'hFFFF)) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`else
    assign xfer_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: scoreboard of expected extensions, stall,
// back-to-back, mid-stream reset, handshake counter, and a narrow 8->16 instance.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] xfer_cnt;

    logic        n_in_valid;
    logic        n_in_ready;
    logic [7:0]  n_in_imm;
    logic [1:0]  n_in_mode;
    logic        n_out_valid;
    logic        n_out_ready;
    logic [15:0] n_out_data;
    logic [15:0] n_xfer_cnt;

    int          checks = 0;
    int          errors = 0;
    int          del_cnt = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    imm_ext_pipe #(.IN_W(16), .OUT_W(32)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .xfer_cnt  (xfer_cnt)
    );

    imm_ext_pipe #(.IN_W(8), .OUT_W(16)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (n_in_valid),
        .in_ready  (n_in_ready),
        .in_imm    (n_in_imm),
        .in_mode   (n_in_mode),
        .out_valid (n_out_valid),
        .out_ready (n_out_ready),
        .out_data  (n_out_data),
        .xfer_cnt  (n_xfer_cnt)
    );

    function automatic logic [31:0] ext_model(input logic [15:0] imm, input logic [1:0] mode);
        logic [31:0] s;
        s = {{16{imm[15]}}, imm};
        case (mode)
            2'b00:   return s;
            2'b01:   return {16'h0000, imm};
            2'b10:   return {imm, 16'h0000};
            default: return s << 2;
        endcase
    endfunction

    // One clock: drive, observe at negedge, push expected on accept. No comparisons here.
    task automatic tick(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                        input logic rdy, output logic acc, output logic del,
                        output logic vld, output logic [31:0] data);
        in_valid  = v;
        in_imm    = imm;
        in_mode   = mode;
        out_ready = rdy;
        @(negedge clk);
        acc  = in_valid && in_ready;
        del  = out_valid && out_ready;
        vld  = out_valid;
        data = out_data;
        if (acc) sb.push_back(ext_model(imm, mode));
        if (del) del_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b1;
        n_in_valid = 1'b0; n_in_imm = '0; n_in_mode = '0; n_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || xfer_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b out_data=%h xfer_cnt=%h, want 0/0/0",
                     out_valid, out_data, xfer_cnt);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_modes();
        logic [15:0] imms[5]   = '{16'h8004, 16'h8004, 16'h1234, 16'hFFFF, 16'h7FFF};
        logic [1:0]  modes[5]  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
        logic [31:0] consts[5] = '{32'hFFFF8004, 32'h00008004, 32'h12340000,
                                   32'hFFFFFFFC, 32'h0001FFFC};
        logic acc, del, vld;
        logic [31:0] data, exp;
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) tick(1'b1, imms[i], modes[i], 1'b1, acc, del, vld, data);
            else       tick(1'b0, 16'h0, 2'b00, 1'b1, acc, del, vld, data);
            if (i < 5) begin
                checks++;
                if (acc !== 1'b1) begin
                    errors++;
                    $display("FAIL modes_accept[%0d]: got %b want 1", i, acc);
                end
            end
            if (i > 0) begin
                checks++;
                if (del !== 1'b1 || data !== consts[i-1]) begin
                    errors++;
                    $display("FAIL modes_const[%0d]: del=%b data=%h want 1/%h",
                             i - 1, del, data, consts[i-1]);
                end
                if (del && sb.size() > 0) begin
                    exp = sb.pop_front();
                    checks++;
                    if (data !== exp) begin
                        errors++;
                        $display("FAIL modes_sb[%0d]: got %h want %h", i - 1, data, exp);
                    end
                end
            end
        end
    endtask

    task automatic test_stall();
        logic acc, del, vld;
        logic [31:0] data, exp;
        tick(1'b1, 16'h0001, 2'b01, 1'b0, acc, del, vld, data);
        tick(1'b1, 16'h0002, 2'b01, 1'b0, acc, del, vld, data);
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL stall_second_accept: got %b want 1", acc);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 16'h0003, 2'b01, 1'b0, acc, del, vld, data);
            checks++;
            if (acc !== 1'b0 || in_ready !== 1'b0 || vld !== 1'b1 || data !== 32'h1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: acc=%b in_ready=%b vld=%b data=%h want 0/0/1/1",
                         i, acc, in_ready, vld, data);
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 16'h0, 2'b00, 1'b1, acc, del, vld, data);
            checks++;
            if (del !== 1'b1 || data !== 32'(i + 1)) begin
                errors++;
                $display("FAIL stall_drain[%0d]: del=%b data=%h want 1/%h", i, del, data, i + 1);
            end
            if (del && sb.size() > 0) begin
                exp = sb.pop_front();
                checks++;
                if (data !== exp) begin
                    errors++;
                    $display("FAIL stall_sb[%0d]: got %h want %h", i, data, exp);
                end
            end
        end
        tick(1'b0, 16'h0, 2'b00, 1'b1, acc, del, vld, data);
        checks++;
        if (vld !== 1'b0) begin
            errors++;
            $display("FAIL stall_empty: out_valid=%b want 0", vld);
        end
    endtask

    task automatic test_back_to_back();
        logic acc, del, vld;
        logic [31:0] data, exp;
        int n_del = 0;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) tick(1'b1, 16'h8100 + 16'(i), 2'(i), 1'b1, acc, del, vld, data);
            else       tick(1'b0, 16'h0, 2'b00, 1'b1, acc, del, vld, data);
            if (i < 8) begin
                checks++;
                if (acc !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_accept[%0d]: got %b want 1", i, acc);
                end
            end
            if (i > 0) begin
                if (del) n_del++;
                checks++;
                if (del !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_deliver[%0d]: got %b want 1", i - 1, del);
                end else if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    checks++;
                    if (data !== exp) begin
                        errors++;
                        $display("FAIL b2b_sb[%0d]: got %h want %h", i - 1, data, exp);
                    end
                end
            end
        end
        checks++;
        if (n_del != 8 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: delivered %0d left %0d want 8/0", n_del, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        logic acc, del, vld;
        logic [31:0] data, exp;
        tick(1'b1, 16'h5555, 2'b00, 1'b0, acc, del, vld, data);
        tick(1'b1, 16'h6666, 2'b00, 1'b0, acc, del, vld, data);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || xfer_cnt !== 16'h0) begin
            errors++;
            $display("FAIL midreset_state: out_valid=%b out_data=%h xfer_cnt=%h want 0/0/0",
                     out_valid, out_data, xfer_cnt);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        del_cnt = 0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_in_ready: got %b want 1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 16'h0, 2'b00, 1'b1, acc, del, vld, data);
            checks++;
            if (vld !== 1'b0) begin
                errors++;
                $display("FAIL midreset_stale[%0d]: out_valid=%b data=%h want 0", i, vld, data);
            end
        end
        tick(1'b1, 16'h00AA, 2'b01, 1'b1, acc, del, vld, data);
        tick(1'b0, 16'h0, 2'b00, 1'b1, acc, del, vld, data);
        checks++;
        if (del !== 1'b1 || data !== 32'h000000AA) begin
            errors++;
            $display("FAIL midreset_new: del=%b data=%h want 1/000000aa", del, data);
        end
        if (del && sb.size() > 0) exp = sb.pop_front();
    endtask

    task automatic test_stats();
        logic acc, del, vld;
        logic [31:0] data;
        logic [15:0] want;
        want = (del_cnt > 16'hFFFF) ? 16'hFFFF : 16'(del_cnt);
`ifdef IMM_EXT_STATS_EN
        checks++;
        if (xfer_cnt !== want) begin
            errors++;
            $display("FAIL stats_count: got %h want %h", xfer_cnt, want);
        end
        for (int i = 0; i < 70000; i++) begin
            tick(1'b1, 16'(i), 2'b00, 1'b1, acc, del, vld, data);
            if (del && sb.size() > 0) void'(sb.pop_front());
        end
        checks++;
        if (xfer_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL stats_saturate: got %h want ffff", xfer_cnt);
        end
`else
        want = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 16'(i), 2'b00, 1'b1, acc, del, vld, data);
            if (del && sb.size() > 0) void'(sb.pop_front());
        end
        checks++;
        if (xfer_cnt !== want) begin
            errors++;
            $display("FAIL stats_tied: got %h want %h", xfer_cnt, want);
        end
`endif
        tick(1'b0, 16'h0, 2'b00, 1'b1, acc, del, vld, data);
        if (del && sb.size() > 0) void'(sb.pop_front());
    endtask

    task automatic test_narrow();
        logic [7:0]  imms[4] = '{8'h80, 8'h80, 8'h12, 8'hFF};
        logic [1:0]  modes[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [15:0] exps[4] = '{16'hFF80, 16'h0080, 16'h1200, 16'hFFFC};
        n_out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            n_in_valid = (i < 4);
            n_in_imm   = (i < 4) ? imms[i] : 8'h00;
            n_in_mode  = (i < 4) ? modes[i] : 2'b00;
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (n_out_valid !== 1'b1 || n_out_data !== exps[i-1]) begin
                    errors++;
                    $display("FAIL narrow[%0d]: valid=%b data=%h want 1/%h",
                             i - 1, n_out_valid, n_out_data, exps[i-1]);
                end
            end
            @(posedge clk);
            #1;
        end
        n_in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_modes();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_stats();
        test_narrow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
